// File: rtl/fa.sv
// One-bit full adder cell used as the single datapath adder of the
// bit-serial adder.
module fa (
    output logic S,
    output logic Cout,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    // Sum and carry of one bit pair plus incoming carry.
    always_comb begin
        S    = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder cell processes one bit pair per
// clock, LSB first, with the carry held in a flop between cycles. The
// result registers are only written on the final bit, so the partial sum
// being assembled never shows on the sum output.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    // The counter needs one extra bit so that an N=1 instance still has a
    // legal, non-zero-width counter.
    localparam int CW = $clog2(N) + 1;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic          state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  aSh_q,   aSh_d;
    logic [N-1:0]  bSh_q,   bSh_d;
    logic [N-1:0]  sSh_q,   sSh_d;
    logic [N-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;
    logic          done_q,  done_d;

    logic          sBit;
    logic          cBit;
    logic [N-1:0]  sShift;

    fa u_fa (
        .S    (sBit),
        .Cout (cBit),
        .A    (aSh_q[0]),
        .B    (bSh_q[0]),
        .Cin  (carry_q)
    );

    // Next-state logic: capture operands on an accepted start, then shift
    // one bit through the adder per cycle and publish the result on the
    // last bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sSh_d   = sSh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        sShift  = sSh_q >> 1;
        sShift[N-1] = sBit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    aSh_d   = a;
                    bSh_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                aSh_d   = aSh_q >> 1;
                bSh_d   = bSh_q >> 1;
                sSh_d   = sShift;
                carry_d = cBit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = sShift;
                    cout_d  = cBit;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sSh_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sSh_q   <= sSh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that consumes the existing 1-bit full adder `fa`.
- One `fa` instance adds one bit pair per clock, LSB first. The carry is held in a flip-flop between cycles.
- Trades N cycles of latency for a single adder cell. Used where area matters more than throughput.
- Sits downstream of operand sources and upstream of any consumer using the done strobe.

Parameters:
- N, 8, operand and sum width in bits. Legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition. Sampled only when busy=0.
- a  input  N  operand A. Captured on the accepted start edge.
- b  input  N  operand B. Captured on the accepted start edge.
- cin  input  1  carry-in. Captured on the accepted start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
- sum  output  N  result. Held stable until the next done.
- cout  output  1  final carry-out. Held with sum.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE, bit counter=0, carry flop=0.
  - Operand shift registers cleared.
  - busy=0, done=0, sum=0, cout=0.
  - rst has priority over every other input.
- States: IDLE and RUN.
- IDLE:
  - busy=0.
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - Otherwise hold all state.
- RUN:
  - busy=1.
  - Each edge, `fa` computes {c, s} = a_sh[0] + b_sh[0] + carry.
  - a_sh and b_sh shift right by one.
  - s shifts into the MSB of the sum shift register s_sh (right shift).
  - carry<=c and cnt<=cnt+1.
  - On the edge where cnt==N-1 (the last bit):
    - sum<=final s_sh value, including this bit, so bit i of a/b lands in sum[i].
    - cout<=c.
    - done<=1, state<=IDLE.
- done is registered and is high for exactly one cycle. It is deasserted at every other edge.
- Latency and throughput:
  - start sampled at edge E0; the bits are processed at edges E1..EN.
  - done is high in the cycle following edge EN.
  - busy is high from E0 to EN.
  - Throughput is one addition per N+1 cycles; back-to-back is allowed.
- start while busy=1: ignored. No queueing and no effect on the operation in flight.
- start in the done cycle: accepted, because state is already IDLE. sum and cout still hold the previous result until the new done.
- a, b and cin may change freely after the accepted start edge without affecting the result.
- Reset mid-RUN: the operation is abandoned, all outputs go to reset values, and no done is issued.
- Widths:
  - cnt width is $clog2(N)+1 so that N=1 is legal.
  - For N=1: a single RUN cycle, then done.
  - Result: {cout, sum} = a + b + cin, exact modulo 2^(N+1).
- Output registers sum and cout are only written on the done edge. Internal s_sh values are never visible on sum.

Decomposition:
- No shared package is needed. State encoding stays a local 1-bit localparam pair (IDLE=0, RUN=1).
- Sub-module: reuse the existing `fa` cell (ports S, Cout, A, B, Cin) as the single datapath adder.
- The top level contains the FSM, counter, shift registers and carry flop.

Test Plan:
- N=8, a=8'hFF, b=8'h01, cin=0, pulse start -> busy high 8 cycles, then done one cycle with sum=8'h00, cout=1.
- N=8, a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0; done exactly 9 cycles after the start edge.
- Extra start pulse with a=8'hAA, b=8'h55 mid-RUN of the 8'h5A case -> ignored; result stays 8'h97 and busy timing is unchanged.
- start asserted in the done cycle with a=8'h80, b=8'h80, cin=0:
  - sum holds 8'h97 through the run.
  - Next done gives sum=8'h00, cout=1.
- rst pulsed at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done follows. A new start then completes correctly.
- N=1 instance, a=1, b=1, cin=1 -> done 2 cycles after the start edge, sum=1, cout=1.
- Randomised sweep of 1000 operands vs. a reference model of a+b+cin.
